// File: rtl/sm_product_accumulator.sv
// Sign-magnitude product accumulator.
// Sums groups of 16-bit sign-magnitude products (delimited by in_last or by
// MAX_BEATS) in a two's-complement accumulator. Each group produces one
// saturated sign-magnitude result, handed off on a valid/ready output stream.
module sm_product_accumulator #(
  parameter int unsigned MAX_BEATS = 256,
  parameter int unsigned ACC_W     = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sat,
  output logic        out_forced
);

  localparam int unsigned CntW = $clog2(MAX_BEATS) + 1;

  typedef enum logic [0:0] {StAcc, StHold} state_e;

  state_e state_q, state_d;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [15:0]      res_data_q, res_data_d;
  logic             res_sat_q, res_sat_d;
  logic             res_forced_q, res_forced_d;

  logic [ACC_W-1:0] beat_mag, beat_val, sum, sum_abs;
  logic             accept, close, sum_sat;
  logic [15:0]      sum_sm;

  // Beat conversion, running sum and its sign-magnitude encoding.
  // The accumulator is always zero while in StHold (cleared when the result
  // is registered), so acc_q + beat_val also starts a fresh group there.
  always_comb begin
    beat_mag = {{(ACC_W-15){1'b0}}, in_data[14:0]};
    beat_val = in_data[15] ? (~beat_mag + 1'b1) : beat_mag;
    sum      = acc_q + beat_val;
    sum_abs  = sum[ACC_W-1] ? (~sum + 1'b1) : sum;
    sum_sat  = |sum_abs[ACC_W-1:15];
    // A zero sum has a clear sign bit, so negative zero cannot be produced.
    sum_sm   = {sum[ACC_W-1], sum_sat ? 15'h7FFF : sum_abs[14:0]};
    accept   = in_valid & in_ready;
    close    = accept & (in_last | (cnt_q == CntW'(MAX_BEATS - 1)));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAcc;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: clr wins, a closing beat always lands in StHold.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = StAcc;
    end else if (close) begin
      state_d = StHold;
    end else if ((state_q == StHold) && out_ready) begin
      state_d = StAcc;
    end
  end

  // Handshake outputs; in StHold the input only moves when the result retires.
  always_comb begin
    out_valid = (state_q == StHold);
    in_ready  = (state_q == StAcc) | out_ready;
  end

  // Datapath next state: accumulate, register result on close, or clear.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    res_data_d   = res_data_q;
    res_sat_d    = res_sat_q;
    res_forced_d = res_forced_q;
    if (clr) begin
      acc_d        = '0;
      cnt_d        = '0;
      res_data_d   = '0;
      res_sat_d    = 1'b0;
      res_forced_d = 1'b0;
    end else if (close) begin
      acc_d        = '0;
      cnt_d        = '0;
      res_data_d   = sum_sm;
      res_sat_d    = sum_sat;
      res_forced_d = ~in_last;
    end else if (accept) begin
      acc_d = sum;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      res_data_q   <= '0;
      res_sat_q    <= 1'b0;
      res_forced_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      res_data_q   <= res_data_d;
      res_sat_q    <= res_sat_d;
      res_forced_q <= res_forced_d;
    end
  end

  assign out_data   = res_data_q;
  assign out_sat    = res_sat_q;
  assign out_forced = res_forced_q;

endmodule
